// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl -- pipeline sequencing controller for the five-stage MIPS32 core.
//
// Merges stall requests from ID (load-use hazard) and EX (multi-cycle HI/LO
// unit) with the MEM-stage data-bus handshake into a single per-stage freeze
// vector. A bus access that is not acknowledged within TIMEOUT cycles is
// abandoned: the pipeline is flushed and a bus-error exception is requested.
//
// Parameters:
//   TIMEOUT      cycles spent in REQ without bus_ack before an error (1..255)
//
// Ports:
//   clk          core clock, rising edge
//   rst          synchronous active-high reset
//   stallreq_id  load-use hazard detected in ID
//   stallreq_ex  EX multi-cycle unit busy
//   mem_req      instruction in MEM is a load or store
//   mem_we       1 = store, 0 = load (sampled with mem_req)
//   bus_ack      one-cycle bus completion strobe
//   bus_rdata    load data, valid with bus_ack
//   stall        freeze vector [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB [5]0
//   flush        clear all pipeline registers this cycle
//   bus_req      bus request level
//   bus_we       write enable for the current bus access
//   mem_rdata    captured load data toward MEM/WB
//   mem_done     one-cycle pulse: access completed, mem_rdata valid
//   exc_buserr   one-cycle bus-error pulse toward the exception unit
// ---------------------------------------------------------------------------
module pipe_ctrl #(
  parameter logic [7:0] TIMEOUT = 8'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [5:0]  stall,
  output logic        flush,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        exc_buserr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [7:0] LAST_CNT = TIMEOUT - 8'd1;

  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  state_t     state;
  logic [7:0] cnt;
  logic       mem_stall;

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values; blocking assignments here would create order-dependent
  // races between the state, counter and data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      bus_we    <= 1'b0;
      // NOTE: mem_rdata is a single datapath register, not a memory array, so
      // resetting it is cheap and gives MEM/WB a defined value after reset.
      mem_rdata <= 32'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mem_req) begin
            state  <= REQ;
            bus_we <= mem_we;
            cnt    <= 8'd0;
          end
        end
        REQ: begin
          // An ack arriving on the final count still wins over the timeout.
          if (bus_ack) begin
            state     <= DONE;
            mem_rdata <= bus_rdata;
          end else if (cnt == LAST_CNT) begin
            state <= ERR;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs are pure decodes of the state register, so they change
  // only on clock edges and carry no combinational path from the inputs.
  assign bus_req    = (state == REQ);
  assign mem_done   = (state == DONE);
  assign flush      = (state == ERR);
  assign exc_buserr = (state == ERR);

  // The MEM stall is released in DONE (access retires) and ERR (access is
  // flushed) even if mem_req is still high from the frozen MEM stage.
  assign mem_stall = mem_req & ((state == IDLE) | (state == REQ));

  // NOTE: stall gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    stall = STALL_NONE;
    if (state == ERR)     stall = STALL_NONE;
    else if (mem_stall)   stall = STALL_MEM;
    else if (stallreq_ex) stall = STALL_EX;
    else if (stallreq_id) stall = STALL_ID;
  end

endmodule
